// File: rtl/pipe_io_display_pkg.sv
// pipe_io_display_pkg: shared constants for the I/O-port display (digit count, active-low glyphs).
// Revision: 1.0
`default_nettype none

package pipe_io_display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [7:0] DIGIT_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}, entry 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

endpackage

`default_nettype wire

// File: rtl/pipe_io_display_if.sv
// pipe_io_display_if: CPU output words, button/options in, multiplexed display drive out.
// Revision: 1.0
`default_nettype none

interface pipe_io_display_if;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic        page_btn;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        page;

  modport master (
    output out_port0, out_port1, page_btn, blank_lz,
    input  an, seg, dp, page
  );

  modport slave (
    input  out_port0, out_port1, page_btn, blank_lz,
    output an, seg, dp, page
  );
endinterface

`default_nettype wire

// File: rtl/pipe_io_display_seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low 7-segment glyph.
// Revision: 1.0
`default_nettype none

module seg7_decode
  import pipe_io_display_pkg::*;
(
  input  wire logic [3:0] hex,
  output logic      [6:0] glyph
);

  always_comb begin
    glyph = GLYPHS[hex];
  end

endmodule

`default_nettype wire

// File: rtl/pipe_io_display.sv
// pipe_io_display: scans two 32-bit CPU output words onto an 8-digit display, debounced page button.
// Revision: 1.0
`default_nettype none

module pipe_io_display
  import pipe_io_display_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 500000
) (
  input  wire logic        clock,
  input  wire logic        resetn,
  input  wire logic [31:0] out_port0,
  input  wire logic [31:0] out_port1,
  input  wire logic        page_btn,
  input  wire logic        blank_lz,
  output logic      [7:0]  an,
  output logic      [6:0]  seg,
  output logic             dp,
  output logic             page
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [DIV_W-1:0] div;
  digit_idx_t       idx;
  logic [31:0]      shadow0;
  logic [31:0]      shadow1;
  logic             shadow_page;
  logic             sync1;
  logic             sync2;
  logic             deb_level;
  logic [CNT_W-1:0] deb_cnt;

  logic             tick;
  logic [31:0]      cur_word;
  logic             cur_page;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             blank;

  // At the frame-start slot the shadows load on this same edge, so bypass them.
  always_comb begin
    tick     = (div == DIV_W'(SCAN_DIV - 1));
    cur_page = (idx == '0) ? page : shadow_page;
    if (idx == '0) begin
      cur_word = page ? out_port1 : out_port0;
    end else begin
      cur_word = shadow_page ? shadow1 : shadow0;
    end
    nibble = cur_word[{idx, 2'b00} +: 4];
    blank  = blank_lz && (idx != '0) && ((cur_word >> {idx, 2'b00}) == 32'd0);
  end

  seg7_decode u_decode (
    .hex   (nibble),
    .glyph (glyph)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div         <= '0;
      idx         <= '0;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow_page <= 1'b0;
      an          <= DIGIT_OFF;
      seg         <= BLANK;
      dp          <= 1'b1;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        idx <= idx + 1'b1;
        if (idx == '0) begin
          shadow0     <= out_port0;
          shadow1     <= out_port1;
          shadow_page <= page;
        end
        an  <= blank ? DIGIT_OFF : ~(8'b1 << idx);
        seg <= blank ? BLANK : glyph;
        dp  <= ~((idx == '0) && cur_page);
      end
    end
  end

  // Any sample equal to the accepted level is a bounce and restarts the count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      page      <= 1'b0;
    end else begin
      sync1 <= page_btn;
      sync2 <= sync1;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        deb_cnt   <= '0;
        deb_level <= sync2;
        if (sync2) begin
          page <= ~page;
        end
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_io_display.sv
// tb_pipe_io_display: directed scenario tests with SCAN_DIV = 4 and DEB_CYCLES = 3.
// Revision: 1.0
`default_nettype none

module tb_pipe_io_display;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_CYCLES = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [7:0] an_exp [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  // Glyphs for 0x12345678, digit 0 first: 8 7 6 5 4 3 2 1
  logic [6:0] seg_12345678 [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

  pipe_io_display_if dif ();

  pipe_io_display #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .out_port0 (dif.out_port0),
    .out_port1 (dif.out_port1),
    .page_btn  (dif.page_btn),
    .blank_lz  (dif.blank_lz),
    .an        (dif.an),
    .seg       (dif.seg),
    .dp        (dif.dp),
    .page      (dif.page)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Leaves the bench on the negedge where resetn was released (cycle 0).
  task automatic do_reset;
    @(negedge clock);
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    step(1);
    vectors++;
    if (dif.an !== 8'hFF) begin miscompares++; $display("FAIL reset_an: got %h want ff", dif.an); end
    vectors++;
    if (dif.seg !== 7'h7F) begin miscompares++; $display("FAIL reset_seg: got %h want 7f", dif.seg); end
    vectors++;
    if (dif.dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp: got %b want 1", dif.dp); end
    vectors++;
    if (dif.page !== 1'b0) begin miscompares++; $display("FAIL reset_page: got %b want 0", dif.page); end
  endtask

  task automatic test_first_frame;
    dif.out_port0 = 32'h12345678;
    dif.blank_lz  = 1'b0;
    do_reset();
    step(3);
    vectors++;
    if (dif.an !== 8'hFF) begin miscompares++; $display("FAIL first_early_an: got %h want ff", dif.an); end
    step(1);
    vectors++;
    if (dif.dp !== 1'b1) begin miscompares++; $display("FAIL first_dp: got %b want 1", dif.dp); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step(4);
      vectors++;
      if (dif.an !== an_exp[i] || dif.seg !== seg_12345678[i]) begin
        miscompares++;
        $display("FAIL first_digit%0d: got an=%h seg=%h want an=%h seg=%h",
                 i, dif.an, dif.seg, an_exp[i], seg_12345678[i]);
      end
    end
  endtask

  task automatic test_tearing;
    logic [6:0] want;
    dif.out_port0 = 32'h00000000;
    dif.blank_lz  = 1'b0;
    do_reset();
    for (int s = 0; s < 16; s++) begin
      step(4);
      want = (s < 8) ? 7'h40 : 7'h0E;
      vectors++;
      if (dif.an !== an_exp[s % 8] || dif.seg !== want) begin
        miscompares++;
        $display("FAIL tear_slot%0d: got an=%h seg=%h want an=%h seg=%h",
                 s, dif.an, dif.seg, an_exp[s % 8], want);
      end
      if (s == 2) dif.out_port0 = 32'hFFFFFFFF;
    end
  endtask

  task automatic test_blanking;
    logic [7:0] want_an;
    logic [6:0] want_seg;
    dif.out_port0 = 32'h000000A0;
    dif.blank_lz  = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4);
      want_an  = (i < 2) ? an_exp[i] : 8'hFF;
      want_seg = (i == 0) ? 7'h40 : ((i == 1) ? 7'h08 : 7'h7F);
      vectors++;
      if (dif.an !== want_an || dif.seg !== want_seg) begin
        miscompares++;
        $display("FAIL blank_digit%0d: got an=%h seg=%h want an=%h seg=%h",
                 i, dif.an, dif.seg, want_an, want_seg);
      end
    end
    dif.blank_lz = 1'b0;
  endtask

  task automatic test_debounce;
    dif.out_port0 = 32'h11111111;
    dif.out_port1 = 32'h22222222;
    dif.blank_lz  = 1'b0;
    do_reset();
    step(1);
    dif.page_btn = 1'b1;
    step(2);
    dif.page_btn = 1'b0;
    step(7);
    vectors++;
    if (dif.page !== 1'b0) begin miscompares++; $display("FAIL deb_short_pulse: got page=%b want 0", dif.page); end
    dif.page_btn = 1'b1;
    step(6);
    dif.page_btn = 1'b0;
    vectors++;
    if (dif.page !== 1'b1) begin miscompares++; $display("FAIL deb_long_pulse: got page=%b want 1", dif.page); end
    step(20);
    vectors++;
    if (dif.an !== 8'hFE || dif.seg !== 7'h24 || dif.dp !== 1'b0) begin
      miscompares++;
      $display("FAIL deb_page1_digit0: got an=%h seg=%h dp=%b want an=fe seg=24 dp=0", dif.an, dif.seg, dif.dp);
    end
    step(4);
    vectors++;
    if (dif.an !== 8'hFD || dif.seg !== 7'h24 || dif.dp !== 1'b1) begin
      miscompares++;
      $display("FAIL deb_page1_digit1: got an=%h seg=%h dp=%b want an=fd seg=24 dp=1", dif.an, dif.seg, dif.dp);
    end
    vectors++;
    if (dif.page !== 1'b1) begin miscompares++; $display("FAIL deb_release_no_toggle: got page=%b want 1", dif.page); end
  endtask

  task automatic test_reset_mid_frame;
    dif.out_port0 = 32'h12345678;
    dif.out_port1 = 32'h00000000;
    do_reset();
    dif.page_btn = 1'b1;
    step(6);
    dif.page_btn = 1'b0;
    step(18);
    vectors++;
    if (dif.an !== 8'hDF || dif.seg !== 7'h30 || dif.page !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_slot5: got an=%h seg=%h page=%b want an=df seg=30 page=1", dif.an, dif.seg, dif.page);
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if (dif.an !== 8'hFF || dif.seg !== 7'h7F || dif.dp !== 1'b1 || dif.page !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async_reset: got an=%h seg=%h dp=%b page=%b want ff 7f 1 0",
               dif.an, dif.seg, dif.dp, dif.page);
    end
    step(2);
    resetn = 1'b1;
    step(3);
    vectors++;
    if (dif.an !== 8'hFF) begin miscompares++; $display("FAIL mid_restart_early: got an=%h want ff", dif.an); end
    step(1);
    vectors++;
    if (dif.an !== 8'hFE || dif.seg !== 7'h00 || dif.dp !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_restart_digit0: got an=%h seg=%h dp=%b want fe 00 1", dif.an, dif.seg, dif.dp);
    end
  endtask

  initial begin
    dif.out_port0 = 32'h0;
    dif.out_port1 = 32'h0;
    dif.page_btn  = 1'b0;
    dif.blank_lz  = 1'b0;
    test_reset();
    test_first_frame();
    test_tearing();
    test_blanking();
    test_debounce();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
